trace_sample_ctrl: RTL and testbench
====================================

Name: trace_sample_ctrl

Overview:
- Controller for the ECG trace path.
- Decimates incoming ADC samples, writes them circularly into a trace RAM, and serves per-pixel reads to the waveform renderer during scan-out.
- Latches a per-frame scroll base at frame start so a frame never tears.
- Sits between the ADC front end and the background/waveform graph logic; sequences clear, run and hold of the trace.

Parameters:
- SAMPLE_DIV, 200000: clk cycles per stored sample (500 Hz at 100 MHz).
- DEPTH, 640: trace entries, one per screen column.
- AW, 10: RAM address width.
- DW, 10: sample width.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- pixel_tick  in  1  25 MHz enable from the clock divider.
- vsync  in  1  VGA vertical sync, active-low pulse.
- adc_data  in  DW  latest ADC conversion.
- adc_valid  in  1  one-clk strobe qualifying adc_data.
- run_en  in  1  1 = acquire, 0 = freeze trace.
- clear  in  1  one-clk pulse; wipes the trace.
- rd_x  in  AW  current pixel_x from the sync generator.
- rd_sample  out  DW  trace value for column rd_x.
- rd_valid  out  1  rd_sample holds a written sample.
- wr_ptr  out  AW  next write address.
- frame_base  out  AW  oldest-sample address latched for the current frame.
- state  out  2  0 = CLEAR, 1 = RUN, 2 = HOLD, 3 = POST.

Behaviour:
- Reset (reset=0, async) values:
  - state=CLEAR, sweep address 0.
  - wr_ptr=0, frame_base=0, fill count=0.
  - rd_sample=0, rd_valid=0.
  - Divider counter=0; held sample=0.
- Held sample register: loads adc_data on adc_valid. With no adc_valid since the last sample tick, the previous value is rewritten.
- Divider:
  - Counts 0..SAMPLE_DIV-1 in RUN/POST only; the tick fires at terminal count.
  - Cleared on entry to RUN.
- CLEAR state:
  - Writes 0 to address sweep, one per clk, 0..DEPTH-1: DEPTH cycles total.
  - Then wr_ptr=0, fill count=0, and state goes to RUN if run_en=1, else HOLD.
- RUN state:
  - On tick, write held sample at wr_ptr, then wr_ptr+1 with wrap DEPTH-1 → 0.
  - Fill count increments and saturates at DEPTH.
  - run_en=0 → HOLD on the next clk; a tick coinciding with that clk is still written.
- HOLD state: no writes, divider frozen, frame_base frozen. run_en=1 → RUN.
- clear pulse in any state → CLEAR and the sweep restarts at 0. clear wins over a simultaneous tick; that sample is dropped.
- Frame base:
  - On the vsync falling edge (vsync registered, previous=1, current=0), in RUN/POST only:
    - frame_base = wr_ptr if fill count == DEPTH, else 0.
  - One update per frame.
- Read path:
  - On a clk with pixel_tick=1, the read address is captured as (frame_base + rd_x) mod DEPTH.
  - rd_sample is valid one clk later and holds until the next pixel_tick.
  - rd_valid = (rd_x < DEPTH) && (rd_x < fill count), registered alongside rd_sample.
  - rd_x ≥ DEPTH gives rd_valid=0 and rd_sample=0.
- Read/write collision: the same address in the same clk returns the old data.
- During CLEAR, rd_valid=0.
- Addition for (frame_base + rd_x) uses AW+1 bits, with conditional subtract of DEPTH.

Optional Feature:
- Macro: TRACE_TRIGGER_EN.
- With it defined:
  - Extra input trig_level [DW-1:0].
  - In RUN, a written sample satisfying (prev < trig_level && new ≥ trig_level) enters POST.
  - POST writes DEPTH/2 further samples, then goes to HOLD automatically. run_en=0 in POST → HOLD immediately.
  - The result is a trigger-centred frozen beat.
- Without it: no trig_level port, POST is unreachable, and state never equals 3.

Decomposition:
- Package trace_pkg:
  - State encodings CLEAR/RUN/HOLD/POST.
  - DEPTH, AW, DW defaults.
  - Function wrap_add(a, b) returning (a+b) mod DEPTH.
- Sub-module trace_ram: simple dual-port RAM, DEPTH×DW, one write port, synchronous read with 1-clk latency, old-data-on-collision.

Test Plan (SAMPLE_DIV=4, DEPTH=8 overrides):
- Reset release → state=CLEAR for 8 clks, then RUN (run_en=1); wr_ptr=0, rd_valid=0 at all rd_x.
- adc_valid with values 1..10 once per tick → RAM holds 9,10,3..8, wr_ptr=2, fill=8. After the vsync fall, frame_base=2 and rd_x=0 reads 3.
- Only 3 samples written (5,6,7), vsync fall → frame_base=0; rd_x=2 → rd_sample=7, rd_valid=1; rd_x=3 → rd_valid=0.
- run_en=0 mid-stream → state=HOLD; wr_ptr and frame_base stay constant across two vsync falls. run_en=1 → first write occurs 4 clks later.
- clear asserted in the same clk as a sample tick → no write, state=CLEAR, all entries read 0 afterwards.
- With TRACE_TRIGGER_EN, trig_level=50, samples 10,20,60,… → POST after 60 is written, HOLD after 4 more writes, state=2.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the ECG trace path: state encodings, default sizes and
// the circular-address helper used by the scan-out read path.
package trace_pkg;

  localparam int TRACE_SAMPLE_DIV = 200000;
  localparam int TRACE_DEPTH      = 640;
  localparam int TRACE_AW         = 10;
  localparam int TRACE_DW         = 10;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_POST  = 2'd3
  } state_t;

  // (a + b) mod depth for a, b < depth: one extra bit, one conditional subtract.
  function automatic logic [TRACE_AW-1:0] wrap_add(input logic [TRACE_AW-1:0] a,
                                                   input logic [TRACE_AW-1:0] b,
                                                   input logic [TRACE_AW:0]   depth);
    logic [TRACE_AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= depth) sum = sum - depth;
    return sum[TRACE_AW-1:0];
  endfunction

endpackage

// File: rtl/trace_sample_ctrl_if.sv
// ADC sample strobe and per-pixel read bus between the front end / sync
// generator (master) and the trace controller (slave).
interface trace_sample_ctrl_if
  import trace_pkg::*;
#(
  parameter int AW = TRACE_AW,
  parameter int DW = TRACE_DW
);
  // No ready signals: adc_valid qualifies adc_data for exactly one clk and is
  // always accepted; pixel_tick captures rd_x, and rd_sample/rd_valid answer it
  // one clk later and hold until the next pixel_tick.
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          pixel_tick;
  logic [AW-1:0] rd_x;
  logic [DW-1:0] rd_sample;
  logic          rd_valid;

  modport master (output adc_valid, adc_data, pixel_tick, rd_x,
                  input  rd_sample, rd_valid);
  modport slave  (input  adc_valid, adc_data, pixel_tick, rd_x,
                  output rd_sample, rd_valid);
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, registered read with one clk of
// latency; a same-address read and write in one clk returns the old data.
module trace_ram #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/trace_sample_ctrl.sv
// ECG trace controller: decimates ADC samples into a circular trace RAM and
// serves tear-free per-pixel reads. Define TRACE_TRIGGER_EN for rising-edge capture.
module trace_sample_ctrl
  import trace_pkg::*;
#(
  parameter int SAMPLE_DIV = TRACE_SAMPLE_DIV,
  parameter int DEPTH      = TRACE_DEPTH,
  parameter int AW         = TRACE_AW,
  parameter int DW         = TRACE_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          run_en,
  input  logic          clear,
`ifdef TRACE_TRIGGER_EN
  input  logic [DW-1:0] trig_level,
`endif
  trace_sample_ctrl_if.slave bus,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] frame_base,
  output logic [1:0]    state
);
  localparam int DIVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   sweep_q;
  logic [AW:0]     fill_q;
  logic [DIVW-1:0] div_q;
  logic [DW-1:0]   held_q;
  logic            vs_q, vs_qq;
  logic            acq, tick, sample_we, sweep_done, vs_fall;
  logic            rd_in_range, rd_inr_q, rd_valid_q;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   ram_q;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;

  assign acq        = (state_q == ST_RUN) || (state_q == ST_POST);
  assign tick       = acq && (div_q == DIV_LAST);
  // clear outranks a coinciding tick, so that sample is dropped
  assign sample_we  = tick && !clear;
  assign sweep_done = (state_q == ST_CLEAR) && (sweep_q == LAST) && !clear;
  assign vs_fall    = vs_qq && !vs_q;
  assign state      = state_q;

`ifdef TRACE_TRIGGER_EN
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH/2 - 1);
  logic [DW-1:0] prev_q;
  logic [AW-1:0] post_q;
  logic          trig_hit, post_done;

  assign trig_hit  = sample_we && (state_q == ST_RUN) &&
                     (prev_q < trig_level) && (held_q >= trig_level);
  assign post_done = sample_we && (state_q == ST_POST) && (post_q == POST_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= '0;
      post_q <= '0;
    end else begin
      if (sweep_done)     prev_q <= '0;
      else if (sample_we) prev_q <= held_q;
      if (state_q != ST_POST) post_q <= '0;
      else if (sample_we)     post_q <= post_q + AW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_CLEAR: if (sweep_q == LAST) state_d = run_en ? ST_RUN : ST_HOLD;
        ST_RUN: begin
          if (!run_en) state_d = ST_HOLD;
`ifdef TRACE_TRIGGER_EN
          else if (trig_hit) state_d = ST_POST;
`endif
        end
        ST_HOLD: if (run_en) state_d = ST_RUN;
        ST_POST: begin
`ifdef TRACE_TRIGGER_EN
          if (!run_en || post_done) state_d = ST_HOLD;
`else
          state_d = ST_HOLD;
`endif
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      sweep_q    <= '0;
      wr_ptr     <= '0;
      frame_base <= '0;
      fill_q     <= '0;
      div_q      <= '0;
      held_q     <= '0;
      vs_q       <= 1'b1;
      vs_qq      <= 1'b1;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      vs_qq   <= vs_q;
      if (bus.adc_valid) held_q <= bus.adc_data;

      if ((state_d == ST_RUN) && (state_q != ST_RUN)) div_q <= '0;
      else if (acq) div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIVW'(1);

      if (clear)                      sweep_q <= '0;
      else if (state_q == ST_CLEAR)   sweep_q <= (sweep_q == LAST) ? '0 : sweep_q + AW'(1);

      if (sweep_done) begin
        wr_ptr <= '0;
        fill_q <= '0;
      end else if (sample_we) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        if (fill_q != DEPTH_W) fill_q <= fill_q + (AW+1)'(1);
      end

      // Until the trace has wrapped, the oldest sample is still at address 0.
      if (vs_fall && acq) frame_base <= (fill_q == DEPTH_W) ? wr_ptr : '0;
    end
  end

  assign rd_in_range = ({1'b0, bus.rd_x} < DEPTH_W);
  assign rd_addr     = rd_in_range ? wrap_add(frame_base, bus.rd_x, DEPTH_W) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_inr_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (bus.pixel_tick) rd_inr_q <= rd_in_range;
      if ((state_d == ST_CLEAR) || (state_q == ST_CLEAR)) rd_valid_q <= 1'b0;
      else if (bus.pixel_tick) rd_valid_q <= rd_in_range && ({1'b0, bus.rd_x} < fill_q);
    end
  end

  assign bus.rd_sample = rd_inr_q ? ram_q : '0;
  assign bus.rd_valid  = rd_valid_q;

  assign ram_we    = (state_q == ST_CLEAR) || sample_we;
  assign ram_waddr = (state_q == ST_CLEAR) ? sweep_q : wr_ptr;
  assign ram_wdata = (state_q == ST_CLEAR) ? '0 : held_q;

  trace_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (bus.pixel_tick),
    .raddr (rd_addr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_trace_sample_ctrl.sv
// Directed bench for trace_sample_ctrl with SAMPLE_DIV=4, DEPTH=8; the trigger
// scenario follows TRACE_TRIGGER_EN when it is defined.
module tb_trace_sample_ctrl;
  logic       clk;
  logic       reset;
  logic       vsync;
  logic       run_en;
  logic       clear;
  logic [9:0] wr_ptr;
  logic [9:0] frame_base;
  logic [1:0] state;
`ifdef TRACE_TRIGGER_EN
  logic [9:0] trig_level;
`endif
  int total;
  int bad;

  trace_sample_ctrl_if #(.AW(10), .DW(10)) bus ();

  trace_sample_ctrl #(.SAMPLE_DIV(4), .DEPTH(8), .AW(10), .DW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .run_en     (run_en),
    .clear      (clear),
`ifdef TRACE_TRIGGER_EN
    .trig_level (trig_level),
`endif
    .bus        (bus.slave),
    .wr_ptr     (wr_ptr),
    .frame_base (frame_base),
    .state      (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: every step leaves the bench 1 ns after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One sample period: strobe v, then wait until just after the tick edge.
  task automatic feed(input logic [9:0] v);
    bus.adc_data  = v;
    bus.adc_valid = 1'b1;
    step(1);
    bus.adc_valid = 1'b0;
    step(3);
  endtask

  task automatic test_reset;
    #3;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state); end
    total++; if (wr_ptr !== 10'd0) begin bad++; $display("FAIL rst_wr_ptr: got %0d want 0", wr_ptr); end
    total++; if (frame_base !== 10'd0) begin bad++; $display("FAIL rst_frame_base: got %0d want 0", frame_base); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %0d want 0", bus.rd_valid); end
    total++; if (bus.rd_sample !== 10'd0) begin bad++; $display("FAIL rst_rd_sample: got %0d want 0", bus.rd_sample); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.rd_x = 10'(i);
      step(1);
      total++; if (state !== 2'd0) begin bad++; $display("FAIL clear_hold_%0d: got %0d want 0", i, state); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL clear_rdv_%0d: got %0d want 0", i, bus.rd_valid); end
    end
    step(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL clear_to_run: got %0d want 1", state); end
    total++; if (wr_ptr !== 10'd0) begin bad++; $display("FAIL run_wr_ptr0: got %0d want 0", wr_ptr); end
  endtask

  task automatic test_fill;
    for (int v = 1; v <= 10; v++) feed(10'(v));
    total++; if (wr_ptr !== 10'd2) begin bad++; $display("FAIL fill_wr_ptr: got %0d want 2", wr_ptr); end
    vsync = 1'b0;
    step(2);
    total++; if (frame_base !== 10'd2) begin bad++; $display("FAIL fill_frame_base: got %0d want 2", frame_base); end
    bus.rd_x = 10'd0;
    step(1);
    total++; if (bus.rd_sample !== 10'd3) begin bad++; $display("FAIL fill_rd_x0: got %0d want 3", bus.rd_sample); end
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL fill_rdv_x0: got %0d want 1", bus.rd_valid); end
    // drop run_en so the next clk is also a tick: that sample (10) still lands at 2
    vsync  = 1'b1;
    run_en = 1'b0;
    step(1);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL stop_state: got %0d want 2", state); end
    total++; if (wr_ptr !== 10'd3) begin bad++; $display("FAIL stop_last_write: got %0d want 3", wr_ptr); end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 2; k++) begin
      vsync = 1'b0;
      step(2);
      vsync = 1'b1;
      step(2);
      total++; if (frame_base !== 10'd2) begin bad++; $display("FAIL hold_fb_%0d: got %0d want 2", k, frame_base); end
      total++; if (wr_ptr !== 10'd3) begin bad++; $display("FAIL hold_wp_%0d: got %0d want 3", k, wr_ptr); end
    end
    // RAM is now 9,10,10,4,5,6,7,8 with frame_base 2
    bus.rd_x = 10'd0; step(1);
    total++; if (bus.rd_sample !== 10'd10) begin bad++; $display("FAIL hold_rd_x0: got %0d want 10", bus.rd_sample); end
    bus.rd_x = 10'd6; step(1);
    total++; if (bus.rd_sample !== 10'd9) begin bad++; $display("FAIL hold_rd_wrap: got %0d want 9", bus.rd_sample); end
    bus.rd_x = 10'd7; step(1);
    total++; if (bus.rd_sample !== 10'd10) begin bad++; $display("FAIL hold_rd_x7: got %0d want 10", bus.rd_sample); end
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL hold_rdv_x7: got %0d want 1", bus.rd_valid); end
    bus.rd_x = 10'd1; step(1);
    total++; if (bus.rd_sample !== 10'd4) begin bad++; $display("FAIL hold_rd_x1: got %0d want 4", bus.rd_sample); end
    bus.pixel_tick = 1'b0;
    bus.rd_x = 10'd6; step(2);
    total++; if (bus.rd_sample !== 10'd4) begin bad++; $display("FAIL no_tick_hold: got %0d want 4", bus.rd_sample); end
    bus.pixel_tick = 1'b1;
    bus.rd_x = 10'd8; step(1);
    total++; if (bus.rd_sample !== 10'd0) begin bad++; $display("FAIL oob_sample: got %0d want 0", bus.rd_sample); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL oob_valid: got %0d want 0", bus.rd_valid); end
    run_en = 1'b1;
    step(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL resume_state: got %0d want 1", state); end
    step(3);
    total++; if (wr_ptr !== 10'd3) begin bad++; $display("FAIL resume_early: got %0d want 3", wr_ptr); end
    step(1);
    total++; if (wr_ptr !== 10'd4) begin bad++; $display("FAIL resume_4clk: got %0d want 4", wr_ptr); end
  endtask

  task automatic test_partial;
    bus.rd_x = 10'd0; step(1);
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL pre_clear_rdv: got %0d want 1", bus.rd_valid); end
    clear = 1'b1; step(1); clear = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL clear_enter: got %0d want 0", state); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL clear_rdv: got %0d want 0", bus.rd_valid); end
    step(7);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL clear_sweep: got %0d want 0", state); end
    step(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL clear_done: got %0d want 1", state); end
    feed(10'd5); feed(10'd6); feed(10'd7);
    total++; if (wr_ptr !== 10'd3) begin bad++; $display("FAIL part_wr_ptr: got %0d want 3", wr_ptr); end
    vsync = 1'b0; step(2);
    total++; if (frame_base !== 10'd0) begin bad++; $display("FAIL part_frame_base: got %0d want 0", frame_base); end
    bus.rd_x = 10'd2; step(1);
    total++; if (bus.rd_sample !== 10'd7) begin bad++; $display("FAIL part_rd_x2: got %0d want 7", bus.rd_sample); end
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL part_rdv_x2: got %0d want 1", bus.rd_valid); end
    // this clk also writes 7 to address 3: the read must see the old 0
    bus.rd_x = 10'd3; step(1);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL part_rdv_x3: got %0d want 0", bus.rd_valid); end
    total++; if (bus.rd_sample !== 10'd0) begin bad++; $display("FAIL collision_old: got %0d want 0", bus.rd_sample); end
    vsync = 1'b1;
  endtask

  task automatic test_clear_tick;
    bus.adc_data  = 10'd99;
    bus.adc_valid = 1'b1; step(1);
    bus.adc_valid = 1'b0; step(2);
    clear  = 1'b1;
    run_en = 1'b0;
    step(1);
    clear = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL ct_state: got %0d want 0", state); end
    total++; if (wr_ptr !== 10'd4) begin bad++; $display("FAIL ct_dropped: got %0d want 4", wr_ptr); end
    step(8);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL ct_hold: got %0d want 2", state); end
    total++; if (wr_ptr !== 10'd0) begin bad++; $display("FAIL ct_wr_ptr: got %0d want 0", wr_ptr); end
    for (int x = 0; x < 8; x++) begin
      bus.rd_x = 10'(x);
      step(1);
      total++; if (bus.rd_sample !== 10'd0) begin bad++; $display("FAIL wiped_%0d: got %0d want 0", x, bus.rd_sample); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL wiped_rdv_%0d: got %0d want 0", x, bus.rd_valid); end
    end
  endtask

  task automatic test_trigger;
    logic [1:0] exp_post;
    logic [1:0] exp_end;
`ifdef TRACE_TRIGGER_EN
    exp_post = 2'd3;
    exp_end  = 2'd2;
`else
    exp_post = 2'd1;
    exp_end  = 2'd1;
`endif
    run_en = 1'b1;
    step(1);
    feed(10'd10); feed(10'd20);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL trig_pre: got %0d want 1", state); end
    feed(10'd60);
    total++; if (state !== exp_post) begin bad++; $display("FAIL trig_fire: got %0d want %0d", state, exp_post); end
    feed(10'd70); feed(10'd80); feed(10'd90);
    total++; if (state !== exp_post) begin bad++; $display("FAIL trig_post3: got %0d want %0d", state, exp_post); end
    feed(10'd100);
    total++; if (state !== exp_end) begin bad++; $display("FAIL trig_end: got %0d want %0d", state, exp_end); end
    total++; if (wr_ptr !== 10'd7) begin bad++; $display("FAIL trig_wr_ptr: got %0d want 7", wr_ptr); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    vsync = 1'b1;
    run_en = 1'b1;
    clear = 1'b0;
`ifdef TRACE_TRIGGER_EN
    trig_level = 10'd50;
`endif
    bus.adc_valid  = 1'b0;
    bus.adc_data   = '0;
    bus.pixel_tick = 1'b1;
    bus.rd_x       = '0;
    test_reset();
    test_fill();
    test_hold();
    test_partial();
    test_clear_tick();
    test_trigger();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
